// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: ROM address/data, execute redirect, decode valid/ready.
// master = fetch_unit side, slave = the ROM/execute/decode side.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, fault,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, fault,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, hides the ROM's 1-cycle read latency, 2-entry output buffer.
// Optional out-of-range fault enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q;
  logic        infl_v;
  logic [31:0] infl_pc;
  entry_t      mem [2];
  logic [1:0]  count;
  logic        wptr;
  logic        rptr;

  logic        pop;
  logic [2:0]  occ;
  logic        credit;
  logic        issue;

  assign pop    = bus.out_valid && bus.out_ready;
  // Slots committed after this edge; keeping it below 2 guarantees every return has room.
  assign occ    = {1'b0, count} + {2'b00, infl_v} - {2'b00, pop};
  assign credit = !bus.redirect_valid && (occ < 3'd2);

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q;
  logic oob;

  assign oob       = ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));
  assign issue     = credit && !fault_q && !oob;
  assign bus.fault = fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (bus.redirect_valid)
      fault_q <= 1'b0;
    else if (credit && !fault_q && oob)
      fault_q <= 1'b1;
  end
`else
  assign issue     = credit;
  assign bus.fault = 1'b0;
`endif

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = mem[rptr].pc;
  assign bus.out_instr = mem[rptr].instr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC & WORD_MASK;
      infl_v  <= 1'b0;
      infl_pc <= '0;
      count   <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      // NOTE: the buffer is only two entries and drives out_pc/out_instr
      // directly, so it is reset to give defined zero outputs after reset.
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else if (bus.redirect_valid) begin
      pc_q   <= bus.redirect_pc & WORD_MASK;
      infl_v <= 1'b0;
      count  <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        infl_pc <= pc_q;
        pc_q    <= pc_q + 32'd4;
      end
      if (infl_v) begin
        mem[wptr] <= '{pc: infl_pc, instr: bus.imem_instr};
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      count <= count + {1'b0, infl_v} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, transfer scoreboard, cycle-exact timing checks.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_if bus ();

  int checks;
  int errors;
  logic [31:0] sb [$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word k holds A000_0000 + k, registered read.
  always @(posedge clk)
    bus.imem_instr <= 32'hA000_0000 + {2'b00, bus.imem_addr[31:2]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back(first + 32'(4 * i));
  endtask

  // Every completed transfer must match the next expected PC in order.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_pc = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check("xfer_pc", bus.out_pc, exp_pc);
      check("xfer_instr", bus.out_instr, 32'hA000_0000 + {2'b00, exp_pc[31:2]});
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    repeat (3) next_cycle();

    // cycle 0
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_fault", {31'b0, bus.fault}, 32'd0);
    expect_pcs(32'h0, 6);
    next_cycle();  // c1
    check("c1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // c2
    check("c2_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("c2_out_pc", bus.out_pc, 32'h0);
    next_cycle();  // c3: stall begins
    bus.out_ready = 1'b0;
    repeat (4) next_cycle();  // c7
    check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
    check("stall_head", bus.out_pc, 32'h4);
    check("stall_pc_hold", bus.imem_addr, 32'hC);
    next_cycle();  // c8: release
    bus.out_ready = 1'b1;
    repeat (5) next_cycle();  // c13: redirect with an entry buffered and one in flight
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    next_cycle();  // c14
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    expect_pcs(32'h40, 4);
    check("redir_r1_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // c15
    check("redir_r2_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // c16
    check("redir_r3_valid", {31'b0, bus.out_valid}, 32'd1);
    check("redir_r3_pc", bus.out_pc, 32'h40);
    repeat (3) next_cycle();  // c19
    next_cycle();  // c20: back-to-back redirects
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h10;
    next_cycle();  // c21
    bus.redirect_pc = 32'h20;
    next_cycle();  // c22
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    expect_pcs(32'h20, 3);
    check("b2b_r1_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // c23
    check("b2b_r2_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // c24
    check("b2b_first_pc", bus.out_pc, 32'h20);
    next_cycle();
    next_cycle();  // c26
    next_cycle();  // c27: fill buffer
    bus.out_ready = 1'b0;
    next_cycle();  // c28: reset mid-stream with count=2
    check("full_valid", {31'b0, bus.out_valid}, 32'd1);
    check("full_head", bus.out_pc, 32'h2C);
    rst_n = 1'b0;
    next_cycle();  // new cycle 0
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mrst_out_pc", bus.out_pc, 32'h0);
    check("mrst_out_instr", bus.out_instr, 32'h0);
    check("mrst_imem_addr", bus.imem_addr, 32'h0);
    expect_pcs(32'h0, 3);
    next_cycle();
    check("mrst_c1_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();
    check("mrst_c2_valid", {31'b0, bus.out_valid}, 32'd1);
    check("mrst_c2_pc", bus.out_pc, 32'h0);
    next_cycle();
    next_cycle();
    next_cycle();  // c5
    bus.out_ready = 1'b0;

`ifdef FETCH_BOUNDS_CHECK_EN
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h70;
    next_cycle();  // R+1
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    expect_pcs(32'h70, 4);
    repeat (5) next_cycle();  // R+6
    check("oob_fault", {31'b0, bus.fault}, 32'd1);
    check("oob_pc_hold", bus.imem_addr, 32'h80);
    check("oob_last_pc", bus.out_pc, 32'h7C);
    next_cycle();  // R+7
    check("oob_drained", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // R+8
    check("oob_sticky", {31'b0, bus.fault}, 32'd1);
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    next_cycle();  // R+9
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    expect_pcs(32'h0, 1);
    check("fault_clear", {31'b0, bus.fault}, 32'd0);
    next_cycle();
    check("oob_r2_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();  // R+11
    check("oob_r3_valid", {31'b0, bus.out_valid}, 32'd1);
    check("oob_r3_pc", bus.out_pc, 32'h0);
    next_cycle();
    bus.out_ready = 1'b0;
`else
    check("fault_tied", {31'b0, bus.fault}, 32'd0);
`endif

    next_cycle();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
